// File: rtl/FHE_ALU_PKG.sv
// rtl/FHE_ALU_PKG.sv - shared FHE ALU sizing constants and buffer RAM request struct
package FHE_ALU_PKG;

  localparam int E                   = 8;
  localparam int logE                = 3;
  localparam int FSIZE               = 64;
  localparam int logN                = 13;
  localparam int BUFFER_READ_LATENCY = 2;
  localparam int BUFFER_ADDR_BITS    = 16;

  typedef struct packed {
    logic [BUFFER_ADDR_BITS-1:0] raddr;
    logic                        wren;
    logic [BUFFER_ADDR_BITS-1:0] waddr;
    logic [E*FSIZE-1:0]          wdata;
  } BufferRAMTEFsizeInputs;

endpackage

// File: rtl/buffer_ram_responder_pkg.sv
// rtl/buffer_ram_responder_pkg.sv - buffer RAM responder state enum and sizing helper
package buffer_ram_responder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } BufferRAMState;

  // Address bits needed for a power-of-two depth; never narrower than one bit.
  function automatic int buf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/FifoBuffer.sv
// rtl/FifoBuffer.sv - fixed-length resettable delay line
module FifoBuffer #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [CYCLES];

  // Shift the word one stage per cycle; reset empties every stage to zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < CYCLES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < CYCLES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[CYCLES-1];

endmodule

// File: rtl/buffer_ram_lane.sv
// rtl/buffer_ram_lane.sv - one coefficient lane: simple dual-port array, write-first registered read
module buffer_ram_lane
  import buffer_ram_responder_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 1024,
  parameter int AW        = buf_addr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_wen,
  input  logic [AW-1:0]        i_waddr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [DATA_SIZE-1:0] o_rdata
);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DATA_SIZE-1:0] r_rdata;

  // Array write; contents survive reset, the caller gates the enable.
  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read that returns this edge's write data when the addresses collide.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rdata <= '0;
    end else if (i_wen && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/buffer_ram_responder.sv
// rtl/buffer_ram_responder.sv - E-lane buffer RAM responder with self-timed clear sequencer
module buffer_ram_responder
  import FHE_ALU_PKG::*;
  import buffer_ram_responder_pkg::*;
#(
  parameter int LANES     = E,
  parameter int DATA_SIZE = FSIZE,
  parameter int DEPTH     = 1 << (logN - logE),
  parameter int LATENCY   = BUFFER_READ_LATENCY
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  BufferRAMTEFsizeInputs        ram_inputs,
  input  logic [LANES-1:0]             lane_wmask,
  output logic [LANES*DATA_SIZE-1:0]   ram_outputs_rdata,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         write_dropped
);

  localparam int AW = buf_addr_w(DEPTH);

  typedef struct packed {
    BufferRAMState state;
    logic [AW-1:0] count;
    logic          dropped;
  } buffer_ram_regs_t;

  buffer_ram_regs_t reg_current;
  buffer_ram_regs_t reg_next;

  logic                       w_clear_we;
  logic                       w_client_we;
  logic [LANES-1:0]           w_lane_we;
  logic [AW-1:0]              w_waddr;
  logic [AW-1:0]              w_raddr;
  logic [LANES*DATA_SIZE-1:0] w_wdata;
  logic [LANES*DATA_SIZE-1:0] w_array_rdata;
  logic                       w_unused;

  // State, clear counter and drop flag; an interrupted clear is simply abandoned.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      reg_current <= '{state: IDLE, count: '0, dropped: 1'b0};
    end else begin
      reg_current <= reg_next;
    end
  end

  // Clear sequencing: walk every address once, flag client writes that lose to it.
  always_comb begin
    reg_next = reg_current;
    case (reg_current.state)
      IDLE: begin
        if (clear_start) begin
          reg_next.state   = CLEAR;
          reg_next.count   = '0;
          reg_next.dropped = 1'b0;
        end
      end
      CLEAR: begin
        reg_next.count = reg_current.count + 1'b1;
        if (ram_inputs.wren) reg_next.dropped = 1'b1;
        if (reg_current.count == AW'(DEPTH - 1)) reg_next.state = IDLE;
      end
      default: reg_next.state = IDLE;
    endcase
  end

  // The clear write owns the write port while it runs; nothing writes during reset.
  assign w_clear_we  = rstn && (reg_current.state == CLEAR);
  assign w_client_we = rstn && (reg_current.state == IDLE) && ram_inputs.wren;
  assign w_waddr     = w_clear_we ? reg_current.count : ram_inputs.waddr[AW-1:0];
  assign w_raddr     = ram_inputs.raddr[AW-1:0];
  assign w_wdata     = w_clear_we ? '0 : ram_inputs.wdata;
  assign w_unused    = ^{ram_inputs.raddr[BUFFER_ADDR_BITS-1:AW],
                         ram_inputs.waddr[BUFFER_ADDR_BITS-1:AW]};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_we[g] = w_clear_we | (w_client_we & lane_wmask[g]);

    buffer_ram_lane #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH),
      .AW        (AW)
    ) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .i_wen   (w_lane_we[g]),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata[DATA_SIZE*g +: DATA_SIZE]),
      .i_raddr (w_raddr),
      .o_rdata (w_array_rdata[DATA_SIZE*g +: DATA_SIZE])
    );
  end

  if (LATENCY == 1) begin : g_direct
    assign ram_outputs_rdata = w_array_rdata;
  end else begin : g_pipe
    FifoBuffer #(
      .WIDTH  (LANES*DATA_SIZE),
      .CYCLES (LATENCY - 1)
    ) u_out_pipe (
      .clk    (clk),
      .rstn   (rstn),
      .i_data (w_array_rdata),
      .o_data (ram_outputs_rdata)
    );
  end

  assign clear_busy    = (reg_current.state == CLEAR);
  assign write_dropped = reg_current.dropped;

endmodule

// File: tb/tb_buffer_ram_responder.sv
// tb/tb_buffer_ram_responder.sv - self-checking bench for buffer_ram_responder
module tb_buffer_ram_responder;
  import FHE_ALU_PKG::*;

  localparam int L     = 8;
  localparam int DS    = 64;
  localparam int W     = L * DS;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic                  clk = 1'b0;
  logic                  rstn;
  BufferRAMTEFsizeInputs ram_inputs;
  logic [L-1:0]          lane_wmask;
  logic [W-1:0]          rdata;
  logic                  clear_start;
  logic                  clear_busy;
  logic                  write_dropped;

  int n_cmp = 0;
  int n_bad = 0;

  buffer_ram_responder #(
    .LANES     (L),
    .DATA_SIZE (DS),
    .DEPTH     (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .ram_inputs        (ram_inputs),
    .lane_wmask        (lane_wmask),
    .ram_outputs_rdata (rdata),
    .clear_start       (clear_start),
    .clear_busy        (clear_busy),
    .write_dropped     (write_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] d;
    bit           k;
  } exp_t;

  logic [W-1:0] m_mem [DEPTH];
  bit           m_kn  [DEPTH];
  bit           m_clr = 0;
  int           m_cnt = 0;
  bit           m_dropped = 0;
  bit           m_started = 0;
  exp_t         m_q [$];
  exp_t         exp_now;

  initial begin
    exp_t e;
    int   wa;
    int   ra;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_clr = 0;
        m_cnt = 0;
        m_dropped = 0;
        m_q.delete();
        for (int i = 0; i < LAT - 1; i++) m_q.push_back('{d: '0, k: 1'b1});
        exp_now = '{d: '0, k: 1'b1};
        m_started = 1;
      end else begin
        if (m_clr) begin
          m_mem[m_cnt] = '0;
          m_kn[m_cnt]  = 1'b1;
          if (ram_inputs.wren) m_dropped = 1;
          if (m_cnt == DEPTH - 1) m_clr = 0;
          m_cnt = (m_cnt + 1) % DEPTH;
        end else begin
          if (ram_inputs.wren) begin
            wa = int'(ram_inputs.waddr) % DEPTH;
            for (int i = 0; i < L; i++)
              if (lane_wmask[i]) m_mem[wa][DS*i +: DS] = ram_inputs.wdata[DS*i +: DS];
            if (lane_wmask == '1) m_kn[wa] = 1'b1;
          end
          if (clear_start) begin
            m_clr = 1;
            m_cnt = 0;
            m_dropped = 0;
          end
        end
        ra = int'(ram_inputs.raddr) % DEPTH;
        e.d = m_mem[ra];
        e.k = m_kn[ra];
        m_q.push_back(e);
        exp_now = m_q.pop_front();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        if (exp_now.k) check("rdata_model", rdata, exp_now.d);
        check("busy_model", W'(clear_busy), W'(m_clr));
        check("dropped_model", W'(write_dropped), W'(m_dropped));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic write_word(input int addr, input logic [W-1:0] data, input logic [L-1:0] mask);
    ram_inputs.wren  = 1'b1;
    ram_inputs.waddr = 16'(addr);
    ram_inputs.wdata = data;
    lane_wmask       = mask;
    @(negedge clk);
    ram_inputs.wren  = 1'b0;
  endtask

  task automatic read_word(input int addr, output logic [W-1:0] d);
    ram_inputs.raddr = 16'(addr);
    ram_inputs.wren  = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    d = rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] w5;
    logic [W-1:0] w11;
    logic [W-1:0] w22;
    logic [W-1:0] wmix;
    logic [W-1:0] w_aa;
    logic [W-1:0] w_55;
    int           cnt;

    rstn        = 1'b0;
    ram_inputs  = '0;
    lane_wmask  = '1;
    clear_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, '0);
    check("reset_busy", W'(clear_busy), '0);
    check("reset_dropped", W'(write_dropped), '0);
    rstn = 1'b1;

    // write then read, plus address wrap
    for (int i = 0; i < L; i++) w5[DS*i +: DS] = 64'h100 + 64'(i);
    write_word(5, w5, 8'hFF);
    read_word(5, d);
    check("wr_rd_a5", d, w5);
    check("wr_rd_a5_lane7", W'(d[DS*7 +: DS]), W'(64'h107));
    read_word(5 + DEPTH, d);
    check("wrap_a1029", d, w5);

    // same-edge write-first
    w_55 = {64{8'h55}};
    w_aa = {64{8'hAA}};
    write_word(9, w_55, 8'hFF);
    ram_inputs.raddr = 16'd9;
    ram_inputs.wren  = 1'b1;
    ram_inputs.waddr = 16'd9;
    ram_inputs.wdata = w_aa;
    lane_wmask       = 8'hFF;
    @(negedge clk);
    ram_inputs.wren = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("write_first_a9", rdata, w_aa);

    // lane mask
    for (int i = 0; i < L; i++) begin
      w11[DS*i +: DS] = 64'h11;
      w22[DS*i +: DS] = 64'h22;
    end
    wmix = {64'h11, 64'h11, 64'h11, 64'h11, 64'h22, 64'h22, 64'h22, 64'h22};
    write_word(3, w11, 8'hFF);
    write_word(3, w22, 8'h0F);
    read_word(3, d);
    check("lane_mask_a3", d, wmix);

    // full clear with a dropped client write
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    cnt = 0;
    while (clear_busy && cnt < 2000) begin
      cnt++;
      ram_inputs.wren  = (cnt == 500);
      ram_inputs.waddr = 16'd7;
      ram_inputs.wdata = W'(123);
      @(negedge clk);
    end
    ram_inputs.wren = 1'b0;
    check("clear_busy_cycles", W'(cnt), W'(1024));
    check("clear_dropped", W'(write_dropped), W'(1));
    read_word(0, d);
    check("clear_a0", d, '0);
    read_word(1023, d);
    check("clear_a1023", d, '0);
    read_word(7, d);
    check("clear_a7_dropped", d, '0);

    // back-to-back streaming
    for (int a = 0; a < DEPTH; a++) begin
      ram_inputs.raddr = 16'(a);
      ram_inputs.wren  = 1'b1;
      ram_inputs.waddr = 16'((a - 4 + DEPTH) % DEPTH);
      ram_inputs.wdata = W'(a + 1);
      lane_wmask       = 8'hFF;
      @(negedge clk);
    end
    ram_inputs.wren = 1'b0;
    read_word(1020, d);
    check("stream_a1020", d, W'(1));
    read_word(1023, d);
    check("stream_a1023", d, W'(4));
    read_word(1019, d);
    check("stream_a1019", d, W'(1024));
    read_word(300, d);
    check("stream_a300", d, W'(305));
    read_word(299, d);
    check("stream_a299", d, W'(304));

    // reset in the middle of a clear
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    check("clear2_started", W'(clear_busy), W'(1));
    check("clear2_dropped_cleared", W'(write_dropped), W'(0));
    repeat (300) @(negedge clk);
    rstn             = 1'b0;
    ram_inputs.wren  = 1'b1;
    ram_inputs.waddr = 16'd300;
    ram_inputs.wdata = W'(64'hDEAD);
    @(negedge clk);
    check("rst_mid_busy", W'(clear_busy), '0);
    check("rst_mid_rdata", rdata, '0);
    rstn            = 1'b1;
    ram_inputs.wren = 1'b0;
    @(negedge clk);
    check("rst_release_rdata", rdata, '0);
    read_word(299, d);
    check("rst_mid_a299", d, '0);
    read_word(300, d);
    check("rst_mid_a300", d, W'(305));
    read_word(301, d);
    check("rst_mid_a301", d, W'(306));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
